// File: rtl/cpu_axi_pkg.sv
// Shared constants and helpers for the SRAM-like to AXI bridge.
// The write-header struct is the per-entry layout of the write queue.
package cpu_axi_pkg;

  localparam logic [3:0] ID_INST   = 4'd0;
  localparam logic [3:0] ID_DATA   = 4'd1;
  localparam logic [3:0] WR_ID     = 4'd1;
  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'b0000;
  localparam logic [2:0] AXI_PROT  = 3'b000;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
  } wr_hdr_t;

  // Byte-lane mask for an access of 2**size bytes starting at byte lane offset.
  function automatic logic [7:0] size_to_strb(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      2'd3:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/axi_wr_fifo.sv
// Write queue: holds accepted data-port writes; the head drives AW and W
// independently and retires once both of its handshakes have completed.
module axi_wr_fifo
  import cpu_axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int WR_OS  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [31:0]       push_addr,
  input  logic [1:0]        push_size,
  input  logic [DATA_W-1:0] push_data,
  input  logic              aw_fire,
  input  logic              w_fire,
  output logic              full,
  output logic              empty,
  output logic [3:0]        count,
  output logic [31:0]       head_addr,
  output logic [1:0]        head_size,
  output logic [DATA_W-1:0] head_data,
  output logic              head_aw_done,
  output logic              head_w_done,
  output logic              retire
);

  localparam int         PTR_W = (WR_OS > 1) ? $clog2(WR_OS) : 1;
  localparam logic [3:0] DEPTH = 4'(WR_OS);

  wr_hdr_t           hdr_r  [WR_OS];
  logic [DATA_W-1:0] data_r [WR_OS];
  logic [WR_OS-1:0]  aw_done_r;
  logic [WR_OS-1:0]  w_done_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [3:0]        count_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(WR_OS - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign empty        = (count_r == 4'd0);
  assign full         = (count_r == DEPTH);
  assign count        = count_r;
  assign head_addr    = hdr_r[rd_ptr_r].addr;
  assign head_size    = hdr_r[rd_ptr_r].size;
  assign head_data    = data_r[rd_ptr_r];
  assign head_aw_done = aw_done_r[rd_ptr_r];
  assign head_w_done  = w_done_r[rd_ptr_r];
  assign retire       = !empty && (head_aw_done || aw_fire) && (head_w_done || w_fire);

  // Entry payload storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      hdr_r[wr_ptr_r]  <= '{addr: push_addr, size: push_size};
      data_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and per-entry handshake progress.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= 4'd0;
      aw_done_r <= {WR_OS{1'b0}};
      w_done_r  <= {WR_OS{1'b0}};
    end else begin
      if (push) begin
        aw_done_r[wr_ptr_r] <= 1'b0;
        w_done_r[wr_ptr_r]  <= 1'b0;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (aw_fire) begin
        aw_done_r[rd_ptr_r] <= 1'b1;
      end
      if (w_fire) begin
        w_done_r[rd_ptr_r] <= 1'b1;
      end
      if (retire) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + {3'b000, push} - {3'b000, retire};
    end
  end

endmodule

// File: rtl/cpu_axi_bridge_mo.sv
// Bridge from two SRAM-like CPU ports (inst, data) to one AXI master with
// multiple outstanding reads per channel and a small posted-write queue.
module cpu_axi_bridge_mo
  import cpu_axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_OS  = 4,
  parameter int WR_OS  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [31:0]         inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [31:0]         data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [3:0]          arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [3:0] RD_MAX = 4'(RD_OS);
  localparam logic [3:0] WR_MAX = 4'(WR_OS);

  logic [3:0]        inst_rd_cnt_r, data_rd_cnt_r, wr_pend_r;
  logic              r_hs_s, inst_r_hs_s, data_r_hs_s, b_hs_s;
  logic              inst_rd_req_s, data_rd_req_s, data_wr_req_s;
  logic              ar_hs_s, inst_ar_hs_s, data_ar_hs_s;
  logic              aw_fire_s, w_fire_s, retire_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [3:0]        fifo_cnt_s;
  logic [31:0]       head_addr_s;
  logic [1:0]        head_size_s;
  logic [DATA_W-1:0] head_data_s;
  logic              head_aw_done_s, head_w_done_s;
  logic [2:0]        off_s;
  logic [7:0]        strb_s;
  logic              unused_ok_s;

  axi_wr_fifo #(.DATA_W(DATA_W), .WR_OS(WR_OS)) u_wr_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push         (data_wr_req_s),
    .push_addr    (data_addr),
    .push_size    (data_size),
    .push_data    (data_wdata),
    .aw_fire      (aw_fire_s),
    .w_fire       (w_fire_s),
    .full         (fifo_full_s),
    .empty        (fifo_empty_s),
    .count        (fifo_cnt_s),
    .head_addr    (head_addr_s),
    .head_size    (head_size_s),
    .head_data    (head_data_s),
    .head_aw_done (head_aw_done_s),
    .head_w_done  (head_w_done_s),
    .retire       (retire_s)
  );

  assign r_hs_s      = rvalid && rready;
  assign inst_r_hs_s = r_hs_s && (rid == ID_INST);
  assign data_r_hs_s = r_hs_s && (rid == ID_DATA);
  assign b_hs_s      = bvalid && bready;

  // A full channel may still issue in the cycle one of its beats returns.
  assign inst_rd_req_s = resetn && inst_req && !inst_wr &&
                         ((inst_rd_cnt_r < RD_MAX) || inst_r_hs_s);
  assign data_rd_req_s = resetn && data_req && !data_wr &&
                         ((data_rd_cnt_r < RD_MAX) || data_r_hs_s) &&
                         fifo_empty_s && (wr_pend_r == 4'd0);
  // Queued plus unanswered writes together never exceed WR_OS.
  assign data_wr_req_s = resetn && data_req && data_wr && !fifo_full_s &&
                         ((fifo_cnt_s + wr_pend_r) < WR_MAX) && (data_rd_cnt_r == 4'd0);

  // AR channel: data read wins over inst read.
  always_comb begin
    arvalid = data_rd_req_s || inst_rd_req_s;
    if (data_rd_req_s) begin
      arid   = ID_DATA;
      araddr = data_addr;
      arsize = {1'b0, data_size};
    end else begin
      arid   = ID_INST;
      araddr = inst_addr;
      arsize = {1'b0, inst_size};
    end
  end

  assign ar_hs_s      = arvalid && arready;
  assign data_ar_hs_s = ar_hs_s && data_rd_req_s;
  assign inst_ar_hs_s = ar_hs_s && !data_rd_req_s;

  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awid    = WR_ID;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = WR_ID;
  assign wlast   = 1'b1;

  assign inst_addr_ok = inst_ar_hs_s;
  assign data_addr_ok = data_ar_hs_s || data_wr_req_s;
  assign rready       = resetn && ((inst_rd_cnt_r != 4'd0) || (data_rd_cnt_r != 4'd0));
  assign bready       = resetn && (wr_pend_r != 4'd0);
  assign inst_data_ok = inst_r_hs_s;
  assign inst_rdata   = rdata;
  assign data_data_ok = data_r_hs_s || b_hs_s;
  assign data_rdata   = rdata;

  // Byte-lane offset of the queue head within one data beat.
  always_comb begin
    if (DATA_W == 64) begin
      off_s = head_addr_s[2:0];
    end else begin
      off_s = {1'b0, head_addr_s[1:0]};
    end
  end

  assign strb_s    = size_to_strb(head_size_s, off_s);
  assign awvalid   = resetn && !fifo_empty_s && !head_aw_done_s;
  assign wvalid    = resetn && !fifo_empty_s && !head_w_done_s;
  assign awaddr    = head_addr_s;
  assign awsize    = {1'b0, head_size_s};
  assign wdata     = head_data_s;
  assign wstrb     = strb_s[DATA_W/8-1:0];
  assign aw_fire_s = awvalid && awready;
  assign w_fire_s  = wvalid && wready;

  assign unused_ok_s = ^{inst_wdata, rresp, rlast, bid, bresp, strb_s};

  // Outstanding read counts per ID and issued-but-unanswered writes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_rd_cnt_r <= 4'd0;
      data_rd_cnt_r <= 4'd0;
      wr_pend_r     <= 4'd0;
    end else begin
      inst_rd_cnt_r <= inst_rd_cnt_r + {3'b000, inst_ar_hs_s} - {3'b000, inst_r_hs_s};
      data_rd_cnt_r <= data_rd_cnt_r + {3'b000, data_ar_hs_s} - {3'b000, data_r_hs_s};
      wr_pend_r     <= wr_pend_r + {3'b000, retire_s} - {3'b000, b_hs_s};
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge_mo.sv
// Directed bench for cpu_axi_bridge_mo; a 64-bit instance shares the control
// stimulus so wide-strobe behaviour is observed alongside the default build.
module tb_cpu_axi_bridge_mo;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata, rdata;
  logic [63:0] inst_wdata64, data_wdata64, rdata64;
  logic        arready, rvalid, rlast, awready, wready, bvalid;
  logic [3:0]  rid, bid;
  logic [1:0]  rresp, bresp;

  logic [31:0] inst_rdata, data_rdata, araddr, awaddr, wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [3:0]  arid, arcache, awid, awcache, wid, wstrb;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wlast, wvalid, bready;

  logic [63:0] inst_rdata_w, data_rdata_w, wdata_w;
  logic [31:0] araddr_w, awaddr_w;
  logic        inst_addr_ok_w, inst_data_ok_w, data_addr_ok_w, data_data_ok_w;
  logic [3:0]  arid_w, arcache_w, awid_w, awcache_w, wid_w;
  logic [7:0]  arlen_w, awlen_w, wstrb_w;
  logic [2:0]  arsize_w, arprot_w, awsize_w, awprot_w;
  logic [1:0]  arburst_w, arlock_w, awburst_w, awlock_w;
  logic        arvalid_w, rready_w, awvalid_w, wlast_w, wvalid_w, bready_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_axi_bridge_mo #(.DATA_W(32), .RD_OS(4), .WR_OS(2)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  cpu_axi_bridge_mo #(.DATA_W(64), .RD_OS(4), .WR_OS(2)) u_dut64 (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata64), .inst_rdata(inst_rdata_w), .inst_addr_ok(inst_addr_ok_w), .inst_data_ok(inst_data_ok_w),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata64), .data_rdata(data_rdata_w), .data_addr_ok(data_addr_ok_w), .data_data_ok(data_data_ok_w),
    .arid(arid_w), .araddr(araddr_w), .arlen(arlen_w), .arsize(arsize_w), .arburst(arburst_w), .arlock(arlock_w),
    .arcache(arcache_w), .arprot(arprot_w), .arvalid(arvalid_w), .arready(arready),
    .rid(rid), .rdata(rdata64), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready_w),
    .awid(awid_w), .awaddr(awaddr_w), .awlen(awlen_w), .awsize(awsize_w), .awburst(awburst_w), .awlock(awlock_w),
    .awcache(awcache_w), .awprot(awprot_w), .awvalid(awvalid_w), .awready(awready),
    .wid(wid_w), .wdata(wdata_w), .wstrb(wstrb_w), .wlast(wlast_w), .wvalid(wvalid_w), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready_w)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0; data_wdata = 32'h0;
    inst_wdata64 = 64'h0; data_wdata64 = 64'h0; rdata64 = 64'h0;
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'b00; bvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    step(); step();
    inst_req = 1'b1; arready = 1'b1;
    #1;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, inst_addr_ok, data_addr_ok, data_data_ok} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00000000",
               {arvalid, awvalid, wvalid, rready, bready, inst_addr_ok, data_addr_ok, data_data_ok});
    end
    step();
    idle();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_ar_priority();
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_addr = 32'h0000_0200; arready = 1'b1;
    #1;
    checks++;
    if ({arvalid, arid, araddr, data_addr_ok, inst_addr_ok} !== {1'b1, 4'd1, 32'h200, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL prio_data_first got v=%b id=%0d addr=%h dok=%b iok=%b want v=1 id=1 addr=200 dok=1 iok=0",
               arvalid, arid, araddr, data_addr_ok, inst_addr_ok);
    end
    checks++;
    if ({arsize, arlen, arburst, arlock, arcache, arprot} !== {3'd2, 8'd0, 2'b01, 2'b00, 4'b0000, 3'b000}) begin
      failures++;
      $display("FAIL ar_fields got size=%0d len=%0d burst=%b want size=2 len=0 burst=01", arsize, arlen, arburst);
    end
    step();
    data_req = 1'b0;
    #1;
    checks++;
    if ({arid, araddr, inst_addr_ok} !== {4'd0, 32'h100, 1'b1}) begin
      failures++;
      $display("FAIL prio_inst_next got id=%0d addr=%h iok=%b want id=0 addr=100 iok=1", arid, araddr, inst_addr_ok);
    end
    step();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0300;
    #1;
    checks++;
    if ({rready, data_addr_ok} !== 2'b10) begin
      failures++;
      $display("FAIL wr_blocked_by_read got rready=%b dok=%b want rready=1 dok=0", rready, data_addr_ok);
    end
    data_req = 1'b0; data_wr = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hDEAD_0001;
    #1;
    checks++;
    if ({data_data_ok, inst_data_ok, data_rdata} !== {1'b1, 1'b0, 32'hDEAD_0001}) begin
      failures++;
      $display("FAIL r_data_route got dok=%b iok=%b rdata=%h want 1 0 dead0001", data_data_ok, inst_data_ok, data_rdata);
    end
    step();
    rid = 4'd0; rdata = 32'hDEAD_0002;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok, inst_rdata} !== {1'b1, 1'b0, 32'hDEAD_0002}) begin
      failures++;
      $display("FAIL r_inst_route got iok=%b dok=%b rdata=%h want 1 0 dead0002", inst_data_ok, data_data_ok, inst_rdata);
    end
    step();
    idle();
    #1;
    checks++;
    if (rready !== 1'b0) begin
      failures++;
      $display("FAIL rready_drained got=%b want=0", rready);
    end
    step();
  endtask

  task automatic test_inst_write_illegal();
    inst_req = 1'b1; inst_wr = 1'b1; arready = 1'b1;
    #1;
    checks++;
    if ({inst_addr_ok, arvalid} !== 2'b00) begin
      failures++;
      $display("FAIL inst_wr_refused got ok=%b arvalid=%b want 0 0", inst_addr_ok, arvalid);
    end
    step();
    idle();
  endtask

  task automatic test_rd_os();
    arready = 1'b1; inst_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h0000_4000 + 32'(4 * i);
      #1;
      checks++;
      if ({inst_addr_ok, arid} !== {1'b1, 4'd0}) begin
        failures++;
        $display("FAIL rd_os_fill%0d got ok=%b id=%0d want ok=1 id=0", i, inst_addr_ok, arid);
      end
      step();
    end
    inst_addr = 32'h0000_4010;
    #1;
    checks++;
    if ({inst_addr_ok, arvalid, rready} !== 3'b001) begin
      failures++;
      $display("FAIL rd_os_limit got ok=%b arvalid=%b rready=%b want 0 0 1", inst_addr_ok, arvalid, rready);
    end
    step();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_00A0;
    #1;
    checks++;
    if ({inst_addr_ok, inst_data_ok, inst_rdata} !== {1'b1, 1'b1, 32'hA0}) begin
      failures++;
      $display("FAIL rd_os_same_cycle got ok=%b dok=%b rdata=%h want 1 1 000000a0", inst_addr_ok, inst_data_ok, inst_rdata);
    end
    step();
    inst_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdata = 32'h0000_00B0 + 32'(i);
      #1;
      checks++;
      if (inst_data_ok !== 1'b1) begin
        failures++;
        $display("FAIL rd_os_drain%0d got=%b want=1", i, inst_data_ok);
      end
      step();
    end
    rvalid = 1'b0;
    #1;
    checks++;
    if (rready !== 1'b0) begin
      failures++;
      $display("FAIL rd_os_empty got rready=%b want=0", rready);
    end
    step();
    idle();
  endtask

  task automatic test_write_order();
    wready = 1'b1; awready = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_1003;
    data_wdata = 32'hAABB_CCDD; data_wdata64 = 64'h0000_0000_AABB_CCDD;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      failures++;
      $display("FAIL wr_accept got=%b want=1", data_addr_ok);
    end
    step();
    data_req = 1'b0; data_wr = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, awsize, wstrb, awaddr, wdata} !== {1'b1, 1'b1, 3'd0, 4'b1000, 32'h1003, 32'hAABB_CCDD}) begin
      failures++;
      $display("FAIL wr_head got av=%b wv=%b size=%0d strb=%b addr=%h data=%h want 1 1 0 1000 00001003 aabbccdd",
               awvalid, wvalid, awsize, wstrb, awaddr, wdata);
    end
    checks++;
    if ({awid, wid, wlast, awlen, awburst} !== {4'd1, 4'd1, 1'b1, 8'd0, 2'b01}) begin
      failures++;
      $display("FAIL wr_fields got awid=%0d wid=%0d wlast=%b len=%0d burst=%b want 1 1 1 0 01",
               awid, wid, wlast, awlen, awburst);
    end
    step();
    #1;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b100) begin
      failures++;
      $display("FAIL w_first got av=%b wv=%b bready=%b want 1 0 0", awvalid, wvalid, bready);
    end
    step(); step();
    awready = 1'b1;
    #1;
    checks++;
    if ({awvalid, bready} !== 2'b10) begin
      failures++;
      $display("FAIL aw_late got av=%b bready=%b want 1 0", awvalid, bready);
    end
    step();
    awready = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      failures++;
      $display("FAIL wr_retired got av=%b wv=%b bready=%b want 0 0 1", awvalid, wvalid, bready);
    end
    bvalid = 1'b1;
    #1;
    checks++;
    if (data_data_ok !== 1'b1) begin
      failures++;
      $display("FAIL wr_bresp got dok=%b want=1", data_data_ok);
    end
    step();
    idle();
    #1;
    checks++;
    if ({bready, data_data_ok} !== 2'b00) begin
      failures++;
      $display("FAIL wr_done got bready=%b dok=%b want 0 0", bready, data_data_ok);
    end
    step();
  endtask

  task automatic test_wr_os();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    for (int i = 0; i < 2; i++) begin
      data_addr = 32'h0000_2000 + 32'(4 * i);
      #1;
      checks++;
      if (data_addr_ok !== 1'b1) begin
        failures++;
        $display("FAIL wr_os_accept%0d got=%b want=1", i, data_addr_ok);
      end
      step();
    end
    data_addr = 32'h0000_2008;
    #1;
    checks++;
    if (data_addr_ok !== 1'b0) begin
      failures++;
      $display("FAIL wr_os_full got=%b want=0", data_addr_ok);
    end
    step();
    data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    #1;
    checks++;
    if ({awvalid, wvalid, awaddr} !== {1'b1, 1'b1, 32'h2000}) begin
      failures++;
      $display("FAIL wr_os_head0 got av=%b wv=%b addr=%h want 1 1 00002000", awvalid, wvalid, awaddr);
    end
    step();
    #1;
    checks++;
    if (awaddr !== 32'h0000_2004) begin
      failures++;
      $display("FAIL wr_os_head1 got addr=%h want 00002004", awaddr);
    end
    step();
    awready = 1'b0; wready = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000; arready = 1'b1;
    #1;
    checks++;
    if ({data_addr_ok, arvalid, awvalid, bready} !== 4'b0001) begin
      failures++;
      $display("FAIL rd_after_wr_wait got ok=%b arv=%b awv=%b bready=%b want 0 0 0 1",
               data_addr_ok, arvalid, awvalid, bready);
    end
    step();
    bvalid = 1'b1;
    #1;
    checks++;
    if ({data_data_ok, data_addr_ok} !== 2'b10) begin
      failures++;
      $display("FAIL rd_wait_b1 got dok=%b aok=%b want 1 0", data_data_ok, data_addr_ok);
    end
    step();
    #1;
    checks++;
    if ({data_data_ok, data_addr_ok} !== 2'b10) begin
      failures++;
      $display("FAIL rd_wait_b2 got dok=%b aok=%b want 1 0", data_data_ok, data_addr_ok);
    end
    step();
    bvalid = 1'b0;
    #1;
    checks++;
    if ({data_addr_ok, arvalid, arid, araddr} !== {1'b1, 1'b1, 4'd1, 32'h3000}) begin
      failures++;
      $display("FAIL rd_after_b got ok=%b arv=%b id=%0d addr=%h want 1 1 1 00003000",
               data_addr_ok, arvalid, arid, araddr);
    end
    step();
    data_req = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h0000_0055;
    #1;
    checks++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'h55}) begin
      failures++;
      $display("FAIL rd_after_b_data got dok=%b rdata=%h want 1 00000055", data_data_ok, data_rdata);
    end
    step();
    idle();
    step();
  endtask

  task automatic test_wide_strobe();
    awready = 1'b1; wready = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h0000_1006;
    data_wdata = 32'h0000_1234; data_wdata64 = 64'h0000_0000_0000_1234;
    #1;
    checks++;
    if ({data_addr_ok, data_addr_ok_w} !== 2'b11) begin
      failures++;
      $display("FAIL wide_accept got ok32=%b ok64=%b want 1 1", data_addr_ok, data_addr_ok_w);
    end
    step();
    data_req = 1'b0; data_wr = 1'b0;
    #1;
    checks++;
    if ({wstrb_w, awsize_w, wdata_w} !== {8'b1100_0000, 3'd1, 64'h1234}) begin
      failures++;
      $display("FAIL wide_strobe64 got strb=%b size=%0d data=%h want 11000000 1 0000000000001234",
               wstrb_w, awsize_w, wdata_w);
    end
    checks++;
    if (wstrb !== 4'b1100) begin
      failures++;
      $display("FAIL half_strobe32 got strb=%b want 1100", wstrb);
    end
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    step();
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    int accepted;
    arready = 1'b1; inst_req = 1'b1;
    step(); step();
    inst_req = 1'b0;
    #1;
    checks++;
    if (rready !== 1'b1) begin
      failures++;
      $display("FAIL mid_pending got rready=%b want=1", rready);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    #1;
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b00000) begin
      failures++;
      $display("FAIL mid_reset got=%b want=00000", {arvalid, awvalid, wvalid, rready, bready});
    end
    accepted = 0;
    inst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (inst_addr_ok === 1'b1) accepted++;
      step();
    end
    checks++;
    if (accepted !== 4) begin
      failures++;
      $display("FAIL mid_counter_cleared got accepted=%0d want=4", accepted);
    end
    idle();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    idle();
    step();
    test_reset();
    test_ar_priority();
    test_inst_write_illegal();
    test_rd_os();
    test_write_order();
    test_wr_os();
    test_wide_strobe();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
